// File: rtl/apb_mem_pkg.sv
// Shared types and sizing helpers for the parametrised APB4 memory slave.
// Pure declarations; no timing or flow control.
package apb_mem_pkg;

  typedef enum logic {IDLE, ACCESS} apb_mem_state_e;

  localparam int MAX_WAIT = 15;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_param_if.sv
// APB4 bus bundle for the memory slave; master drives request, slave drives response.
// No timing of its own; PREADY carries all backpressure.
interface apb_mem_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      _PSEL1;
  logic                      _PWRITE;
  logic                      _PENABLE;
  logic [ADDR_WIDTH-1:0]     _PADDR;
  logic [DATA_WIDTH-1:0]     _PWDATA;
  logic [DATA_WIDTH/8-1:0]   _PSTRB;
  logic [DATA_WIDTH-1:0]     _PRDATA;
  logic                      _PREADY;
  logic                      _PSLVERR;

  modport master (
    output _PSEL1, _PWRITE, _PENABLE, _PADDR, _PWDATA, _PSTRB,
    input  _PRDATA, _PREADY, _PSLVERR
  );

  modport slave (
    input  _PSEL1, _PWRITE, _PENABLE, _PADDR, _PWDATA, _PSTRB,
    output _PRDATA, _PREADY, _PSLVERR
  );
endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and async clear.
// Write commits on the clock edge; read port is combinational; never stalls.
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [LANES-1:0]      wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_mem_param.sv
// APB4 memory slave: byte strobes, PSLVERR on out-of-range/misaligned address.
// Latency 2 cycles (setup + access) plus WAIT_CYCLES of PREADY=0 when APB_MEM_WAIT_EN is defined.
// Backpressure only via PREADY; PRDATA is registered and held until the next read.
module apb_mem_param
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic            _PCLK,
  input logic            _PRESETn,
  apb_mem_param_if.slave bus
);
  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int OFS_W = lane_bits(DATA_WIDTH);
  localparam int IDX_W = word_idx_width(DEPTH);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * LANES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);

  if (!(DATA_WIDTH inside {8, 16, 32, 64}) || WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT)
  begin : g_bad_param
    $error("apb_mem_param: unsupported DATA_WIDTH or WAIT_CYCLES");
  end

  apb_mem_state_e        state;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_now;
  logic [IDX_W-1:0]      raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err_now;
  logic                  setup;
  logic                  pready;
  logic                  we;
  logic                  cnt_zero;
  logic                  cnt_last;
  logic                  setup_ready;

`ifdef APB_MEM_WAIT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] cnt;
  assign cnt_zero    = (cnt == '0);
  assign cnt_last    = (cnt == CNT_W'(1));
  assign setup_ready = (WAIT_LD == '0);
`else
  assign cnt_zero    = 1'b1;
  assign cnt_last    = 1'b0;
  assign setup_ready = 1'b1;
`endif

  // Upper address bits only matter for the range check, never for indexing.
  assign idx_now = bus._PADDR[OFS_W +: IDX_W];
  assign err_now = ({1'b0, bus._PADDR} >= MEM_BYTES) || ((bus._PADDR & LANE_MASK) != '0);
  assign setup   = bus._PSEL1 && !bus._PENABLE;
  assign pready  = (state == ACCESS) && cnt_zero;
  assign raddr   = (state == IDLE) ? idx_now : idx_q;
  assign we      = pready && bus._PSEL1 && bus._PENABLE && write_q && !err_q;

  assign bus._PREADY  = pready;
  assign bus._PSLVERR = pready && err_q;

  always_ff @(posedge _PCLK or negedge _PRESETn) begin
    if (!_PRESETn) begin
      state        <= IDLE;
      idx_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      bus._PRDATA  <= '0;
`ifdef APB_MEM_WAIT_EN
      cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state   <= ACCESS;
            idx_q   <= idx_now;
            write_q <= bus._PWRITE;
            err_q   <= err_now;
`ifdef APB_MEM_WAIT_EN
            cnt     <= WAIT_LD;
`endif
            if (!bus._PWRITE && setup_ready) bus._PRDATA <= err_now ? '0 : rdata;
          end
        end
        ACCESS: begin
          if (!bus._PSEL1) begin
            state <= IDLE;
          end else if (!cnt_zero) begin
`ifdef APB_MEM_WAIT_EN
            cnt <= cnt - CNT_W'(1);
`endif
            // Read data lands on the edge that raises PREADY.
            if (cnt_last && !write_q) bus._PRDATA <= err_q ? '0 : rdata;
          end else if (bus._PENABLE) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .LANES      (LANES)
  ) u_array (
    .clk   (_PCLK),
    .rst_n (_PRESETn),
    .we    (we),
    .waddr (idx_q),
    .wstrb (bus._PSTRB),
    .wdata (bus._PWDATA),
    .raddr (raddr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_apb_mem_param.sv
// Bench for apb_mem_param: directed cases plus random traffic against a word-array model.
module tb_apb_mem_param;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 256;
`ifdef APB_MEM_WAIT_EN
  localparam int EXP_WAIT = 3;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_mem_param_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  apb_mem_param #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (3)
  ) dut (
    ._PCLK    (clk),
    ._PRESETn (rst_n),
    .bus      (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < DEPTH; w++) mem_m[w] = 32'h0;
    last_rd = 32'h0;
  endtask

  // Caller is positioned just after a rising edge; returns likewise, bus released.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input string tag,
                      output logic [31:0] rd, output logic err, output int waits);
    bit done;
    bus._PSEL1 = 1'b1; bus._PENABLE = 1'b0; bus._PWRITE = wr;
    bus._PADDR = addr; bus._PWDATA = wdata; bus._PSTRB = strb;
    @(negedge clk);
    check({tag, "_setup_pready"}, 64'(bus._PREADY), 64'd0);
    @(posedge clk); #1;
    bus._PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus._PREADY === 1'b1) done = 1'b1;
      else waits++;
    end
    check({tag, "_pready_seen"}, 64'(done), 64'd1);
    rd  = bus._PRDATA;
    err = bus._PSLVERR;
    @(posedge clk); #1;
    bus._PSEL1 = 1'b0; bus._PENABLE = 1'b0;
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input string tag);
    logic [31:0] rd, exp_rd, mask;
    logic        err;
    int          waits;
    bit          exp_err;
    xfer(wr, addr, wdata, strb, tag, rd, err, waits);
    exp_err = (addr >= 32'(DEPTH * 4)) || (addr % 4 != 0);
    check({tag, "_pslverr"}, 64'(err), 64'(exp_err));
    check({tag, "_waits"}, 64'(waits), 64'(EXP_WAIT));
    if (wr) begin
      if (!exp_err) begin
        for (int i = 0; i < 4; i++) begin
          mask = 32'hFF << (8 * i);
          if (strb[i]) mem_m[addr / 4] = (mem_m[addr / 4] & ~mask) | (wdata & mask);
        end
      end
      check({tag, "_prdata_held"}, 64'(rd), 64'(last_rd));
    end else begin
      exp_rd = exp_err ? 32'h0 : mem_m[addr / 4];
      check({tag, "_prdata"}, 64'(rd), 64'(exp_rd));
      last_rd = exp_rd;
    end
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    bit          wr;
    bus._PSEL1 = 1'b0; bus._PENABLE = 1'b0; bus._PWRITE = 1'b0;
    bus._PADDR = '0; bus._PWDATA = '0; bus._PSTRB = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pready",  64'(bus._PREADY),  64'd0);
    check("reset_pslverr", 64'(bus._PSLVERR), 64'd0);
    check("reset_prdata",  64'(bus._PRDATA),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    apb(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr");
    apb(1'b0, 32'h10, 32'h0, 4'h0, "t1_rd");

    apb(1'b1, 32'h20, 32'h11223344, 4'hF, "t2_wr_full");
    apb(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "t2_wr_lanes");
    apb(1'b0, 32'h20, 32'h0, 4'h0, "t2_rd");
    check("t2_lane_merge", 64'(last_rd), 64'h11BB33DD);

    apb(1'b1, 32'h400, 32'h12345678, 4'hF, "t3_wr_oor");
    apb(1'b0, 32'h400, 32'h0, 4'h0, "t3_rd_oor");
    apb(1'b0, 32'h3FC, 32'h0, 4'h0, "t3_rd_last");

    apb(1'b0, 32'h13, 32'h0, 4'h0, "t4_rd_misal");
    apb(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, "t4_wr_misal");
    apb(1'b0, 32'h10, 32'h0, 4'h0, "t4_rd_back");

    apb(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, "t5_wr");
    apb(1'b0, 32'h0, 32'h0, 4'h0, "t5_rd");

    // PSEL dropped during ACCESS: write must not land.
    bus._PSEL1 = 1'b1; bus._PENABLE = 1'b0; bus._PWRITE = 1'b1;
    bus._PADDR = 32'h10; bus._PWDATA = 32'h0BAD0BAD; bus._PSTRB = 4'hF;
    @(posedge clk); #1;
    bus._PSEL1 = 1'b0; bus._PENABLE = 1'b1;
    @(posedge clk); #1;
    bus._PENABLE = 1'b0;
    apb(1'b0, 32'h10, 32'h0, 4'h0, "psel_drop_rd");

    // PENABLE high with no setup phase is ignored.
    bus._PSEL1 = 1'b1; bus._PENABLE = 1'b1; bus._PWRITE = 1'b1;
    bus._PADDR = 32'h20; bus._PWDATA = 32'h0; bus._PSTRB = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_setup_pready", 64'(bus._PREADY), 64'd0);
    end
    @(posedge clk); #1;
    bus._PSEL1 = 1'b0; bus._PENABLE = 1'b0;
    apb(1'b0, 32'h20, 32'h0, 4'h0, "no_setup_rd");

    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      addr = 32'h400 + ($urandom_range(0, 255) << 2);
      else if (r == 1) addr = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
      else             addr = $urandom_range(0, 255) << 2;
      apb(wr, addr, $urandom, 4'($urandom), "rand");
    end

    // Reset in the middle of a write access aborts it.
    bus._PSEL1 = 1'b1; bus._PENABLE = 1'b0; bus._PWRITE = 1'b1;
    bus._PADDR = 32'h8; bus._PWDATA = 32'hCAFEF00D; bus._PSTRB = 4'hF;
    @(posedge clk); #1;
    bus._PENABLE = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pready",  64'(bus._PREADY),  64'd0);
    check("rst_mid_prdata",  64'(bus._PRDATA),  64'd0);
    bus._PSEL1 = 1'b0; bus._PENABLE = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb(1'b0, 32'h8, 32'h0, 4'h0, "rst_rd_word2");
    apb(1'b0, 32'h20, 32'h0, 4'h0, "rst_rd_cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
